alu_seq: RTL and testbench

Registered, parametrised successor to the EXE-stage combinational ALU. It keeps the existing EXE_CMD encoding and NZCV semantics and adds three things:
- an internal status register updated only when the S bit is set;
- a valid/ready input handshake;
- a multi-cycle shift-add multiply (MUL).
It sits in the EXE stage and feeds the status register and the MEM stage.

---
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered EXE-stage ALU with a valid/ready input handshake, an internal NZCV
// status register and an optional multi-cycle shift-add multiply.
module alu_seq #(
    parameter int N      = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         validIn,
    output logic         readyOut,
    input  logic [N-1:0] Val1In,
    input  logic [N-1:0] Val2In,
    input  logic [3:0]   EXE_CMDIn,
    input  logic         SIn,
    output logic [N-1:0] ALU_ResOut,
    output logic         validOut,
    output logic [3:0]   statusOut
);

    localparam int CW = $clog2(N);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e          state_q;
    logic [N-1:0]    res_q;
    logic [3:0]      status_q;
    logic            valid_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    acc_q;
    logic [N-1:0]    mcnd_q;
    logic [N-1:0]    mplr_q;
    logic            s_q;

    logic            is_mul;
    logic            c_in;
    logic [N:0]      wide;
    logic [N-1:0]    sc_res;
    logic            sc_c;
    logic            sc_v;
    logic [3:0]      sc_flags;
    logic [N-1:0]    acc_d;
    logic [3:0]      mul_flags;
    logic            mul_last;

    assign readyOut   = (state_q == S_IDLE);
    assign ALU_ResOut = res_q;
    assign validOut   = valid_q;
    assign statusOut  = status_q;

    assign is_mul = MUL_EN && (EXE_CMDIn == OP_MUL);
    assign c_in   = status_q[1];

    // Single-cycle datapath; carry/borrow is bit N of an N+1 bit operation.
    always_comb begin
        wide   = '0;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (EXE_CMDIn)
            OP_MOV: sc_res = Val2In;
            OP_MVN: sc_res = ~Val2In;
            OP_ADD, OP_ADC: begin
                wide = {1'b0, Val1In} + {1'b0, Val2In};
                if (EXE_CMDIn == OP_ADC) begin
                    wide = wide + {{N{1'b0}}, c_in};
                end
                sc_res = wide[N-1:0];
                sc_c   = wide[N];
                sc_v   = (Val1In[N-1] == Val2In[N-1]) && (sc_res[N-1] != Val1In[N-1]);
            end
            OP_SUB, OP_SBC: begin
                wide = {1'b0, Val1In} - {1'b0, Val2In};
                if (EXE_CMDIn == OP_SBC) begin
                    wide = wide - {{N{1'b0}}, ~c_in};
                end
                sc_res = wide[N-1:0];
                sc_c   = wide[N];
                sc_v   = (Val1In[N-1] != Val2In[N-1]) && (sc_res[N-1] != Val1In[N-1]);
            end
            OP_AND: sc_res = Val1In & Val2In;
            OP_ORR: sc_res = Val1In | Val2In;
            OP_EOR: sc_res = Val1In ^ Val2In;
            default: sc_res = '0;
        endcase
        sc_flags = {sc_res[N-1], (sc_res == '0), sc_c, sc_v};
    end

    // One shift-add step per cycle; the multiplier is consumed LSB first.
    always_comb begin
        acc_d     = acc_q + (mplr_q[0] ? mcnd_q : '0);
        mul_flags = {acc_d[N-1], (acc_d == '0), status_q[1:0]};
        mul_last  = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcnd_q   <= '0;
            mplr_q   <= '0;
            s_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (validIn) begin
                        if (is_mul) begin
                            mcnd_q  <= Val1In;
                            mplr_q  <= Val2In;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            s_q     <= SIn;
                            state_q <= S_MUL;
                        end else begin
                            res_q   <= sc_res;
                            valid_q <= 1'b1;
                            if (SIn) begin
                                status_q <= sc_flags;
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc_q  <= acc_d;
                    mcnd_q <= mcnd_q << 1;
                    mplr_q <= mplr_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (mul_last) begin
                        res_q   <= acc_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        if (s_q) begin
                            status_q <= mul_flags;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus random traffic, checked by a
// scoreboard fed from an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 68;  // {expected completion cycle, status, result}
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic        clk;
    logic        rst;
    logic        validIn;
    logic        readyOut;
    logic [31:0] Val1In;
    logic [31:0] Val2In;
    logic [3:0]  EXE_CMDIn;
    logic        SIn;
    logic [31:0] ALU_ResOut;
    logic        validOut;
    logic [3:0]  statusOut;

    logic [W-1:0] exp_q[$];
    logic [3:0]   m_st;
    int           cyc;
    int           n_checks;
    int           n_pass;

    alu_seq #(.N(32), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .validIn   (validIn),
        .readyOut  (readyOut),
        .Val1In    (Val1In),
        .Val2In    (Val2In),
        .EXE_CMDIn (EXE_CMDIn),
        .SIn       (SIn),
        .ALU_ResOut(ALU_ResOut),
        .validOut  (validOut),
        .statusOut (statusOut)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: returns {new_status, result}.
    function automatic logic [35:0] ref_op(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b, input logic s,
                                           input logic [3:0] st);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned p;
        longint          sr;
        logic [31:0]     r;
        logic            c;
        logic            v;
        int              k;
        c = 1'b0;
        v = 1'b0;
        r = 32'h0;
        case (cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd2, 4'd3: begin
                k  = (cmd == 4'd3) ? int'(st[1]) : 0;
                p  = ua + ub + 64'(k);
                r  = p[31:0];
                c  = (p > 64'hFFFF_FFFF);
                sr = sa + sb + longint'(k);
                v  = (sr > SMAX) || (sr < SMIN);
            end
            4'd4, 4'd5: begin
                k  = (cmd == 4'd5) ? int'(!st[1]) : 0;
                r  = a - b - 32'(k);
                c  = (ua < ub + 64'(k));
                sr = sa - sb - longint'(k);
                v  = (sr > SMAX) || (sr < SMIN);
            end
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            4'd10: begin
                p = ua * ub;
                r = p[31:0];
                c = st[1];
                v = st[0];
            end
            default: r = 32'h0;
        endcase
        return {(s ? {r[31], (r == 32'h0), c, v} : st), r};
    endfunction

    // Driver: waits for readyOut (offering an ignored ADD while busy), then presents one op.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit use_exp, input logic [31:0] er,
                         input logic [3:0] es);
        int          guard;
        logic [35:0] m;
        int          lat;
        guard = 0;
        @(negedge clk);
        while (!readyOut && guard < 100) begin
            validIn   = 1'b1;
            EXE_CMDIn = 4'b0010;
            Val1In    = $urandom;
            Val2In    = $urandom;
            SIn       = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (!readyOut) begin
            n_checks++;
            $display("FAIL ready_timeout: readyOut=%0b expected 1 within 100 cycles", readyOut);
            validIn = 1'b0;
            return;
        end
        m = ref_op(cmd, a, b, s, m_st);
        if (use_exp) m = {(s ? es : m_st), er};
        lat = (cmd == 4'd10) ? 32 : 0;
        exp_q.push_back({32'(cyc + 1 + lat), m});
        m_st      = m[35:32];
        validIn   = 1'b1;
        EXE_CMDIn = cmd;
        Val1In    = a;
        Val2In    = b;
        SIn       = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            validIn = 1'b0;
            Val1In  = $urandom;
            Val2In  = $urandom;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_res"},    64'(ALU_ResOut), 64'h0);
        chk({tag, "_status"}, 64'(statusOut),  64'h0);
        chk({tag, "_valid"},  64'(validOut),   64'h0);
        chk({tag, "_ready"},  64'(readyOut),   64'h1);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst && validOut) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_valid: validOut=1 result=0x%0h with nothing expected (cycle %0d)",
                         ALU_ResOut, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result",  64'(ALU_ResOut), 64'(e[31:0]));
                chk("status",  64'(statusOut),  64'(e[35:32]));
                chk("latency", 64'(cyc),        64'(e[67:36]));
            end
        end
    end

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners[6];
        corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h0001_0001};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int guard;
        n_checks  = 0;
        n_pass    = 0;
        m_st      = 4'h0;
        rst       = 1'b0;
        validIn   = 1'b0;
        Val1In    = '0;
        Val2In    = '0;
        EXE_CMDIn = '0;
        SIn       = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst = 1'b1;

        // Flag/carry chaining
        issue(4'd2, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h0, 4'b0110);
        issue(4'd3, 32'd5, 32'd3, 1'b1, 1'b1, 32'd9, 4'b0000);
        issue(4'd2, 32'd1, 32'd1, 1'b0, 1'b1, 32'd2, 4'b0000);
        idle(2);
        issue(4'd4, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b0001);
        issue(4'd5, 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 4'b0000);
        idle(1);

        // MUL with C preserved; ADDs offered while busy must be dropped
        issue(4'd2, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h0, 4'b0110);
        issue(4'd10, 32'h0001_0001, 32'h0001_0001, 1'b1, 1'b1, 32'h0002_0001, 4'b0010);
        issue(4'd1, 32'h0, 32'hA5A5_0000, 1'b0, 1'b0, 32'h0, 4'h0);
        idle(2);

        // Reset mid-stream, held for two edges
        issue(4'd7, 32'h1234_0000, 32'h0000_5678, 1'b1, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        validIn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("mid_rst");
        exp_q.delete();
        m_st = 4'h0;
        rst = 1'b1;

        // Reset aborting an in-flight MUL on its 10th busy cycle
        issue(4'd2, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 32'h0, 4'h0);
        issue(4'd10, 32'd7, 32'd9, 1'b1, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        validIn = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        m_st = 4'h0;
        rst = 1'b1;
        check_reset_state("mul_abort");
        idle(40);
        issue(4'd1, 32'h0, 32'h55, 1'b1, 1'b1, 32'h55, 4'b0000);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            logic [3:0] cmd;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            cmd = 4'($urandom_range(0, 15));
            if (cmd == 4'd10 && $urandom_range(0, 2) != 0) cmd = 4'd3;
            issue(cmd, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 1'b0, 32'h0, 4'h0);
        end

        // Drain
        idle(1);
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
